halflife_decay_seq: RTL and testbench

//  Upstream sequencer for the half-life up/down counter. Turns two raw buttons (start, pause)

---
 rtl/halflife_pkg.sv | 16 +
 rtl/halflife_decay_seq_btn_sync_edge.sv | 31 +++
 rtl/halflife_decay_seq.sv | 157 +++++++++++++++
 tb/tb_halflife_decay_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halflife_pkg.sv
// Shared types and default widths for the half-life decay sequencer.
package halflife_pkg;

  localparam int N_DEF    = 4;
  localparam int HL_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

endpackage

// File: rtl/halflife_decay_seq_btn_sync_edge.sv
// Raw button -> 2-FF synchronizer -> registered rising-edge pulse.
// The one-cycle pulse appears 3 clocks after the async edge; a held button yields one pulse.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/halflife_decay_seq.sv
// Drives load/down strobes into an external up/down counter so its value halves every
// half-life period; strobes are combinational from state and the sampled counter value.
module halflife_decay_seq
  import halflife_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int PRESCALE   = 4,
  parameter int HALF_TICKS = 10,
  parameter int HL_W       = HL_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start_btn,
  input  logic            i_pause_btn,
  input  logic [N-1:0]    i_init_val,
  input  logic [N-1:0]    i_cnt_val,
  output logic            o_cnt_load,
  output logic            o_cnt_up,
  output logic            o_cnt_down,
  output logic [N-1:0]    o_cnt_in,
  output logic            o_busy,
  output logic            o_done,
  output logic [HL_W-1:0] o_hl_count
);

  localparam int PW = $clog2(PRESCALE);
  localparam int TW = $clog2(HALF_TICKS);

  // A period must be long enough for the largest halving to finish before the next compare.
  if (PRESCALE < 2 || HALF_TICKS < (1 << (N - 1))) begin : g_bad_params
    $error("halflife_decay_seq: need PRESCALE>=2 and HALF_TICKS>=2**(N-1)");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic [TW-1:0]   r_tick;
  logic [TW-1:0]   w_tick_nxt;
  logic [N-1:0]    r_target;
  logic [N-1:0]    w_target_nxt;
  logic [HL_W-1:0] r_hl;
  logic [HL_W-1:0] w_hl_nxt;
  logic [N-1:0]    w_post;
  logic            w_start_p;
  logic            w_pause_p;
  logic            w_tick;

  btn_sync_edge u_start_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_start_btn),
    .o_pulse(w_start_p)
  );

  btn_sync_edge u_pause_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_pause_btn),
    .o_pulse(w_pause_p)
  );

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_tick   <= '0;
      r_target <= '0;
      r_hl     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_tick   <= w_tick_nxt;
      r_target <= w_target_nxt;
      r_hl     <= w_hl_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_tick_nxt   = r_tick;
    w_target_nxt = r_target;
    w_hl_nxt     = r_hl;
    w_post       = i_cnt_val;
    o_cnt_load   = 1'b0;
    o_cnt_down   = 1'b0;
    o_cnt_in     = '0;

    case (r_state)
      IDLE: begin
        if (w_start_p) w_state_nxt = LOAD;
      end

      LOAD: begin
        o_cnt_load  = 1'b1;
        o_cnt_in    = i_init_val;
        w_presc_nxt = '0;
        w_tick_nxt  = '0;
        w_hl_nxt    = '0;
        w_state_nxt = SETTLE;
      end

      SETTLE: begin
        if (i_cnt_val == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_target_nxt = i_cnt_val >> 1;
          w_state_nxt  = RUN;
        end
      end

      RUN: begin
        if (w_start_p) begin
          w_state_nxt = LOAD;
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            o_cnt_down = (i_cnt_val > r_target);
            // The counter has not applied this cycle's down yet, so account for it here.
            w_post = i_cnt_val - N'(o_cnt_down);
            if (r_tick == TW'(HALF_TICKS - 1)) begin
              w_tick_nxt = '0;
              if (r_hl != '1) w_hl_nxt = r_hl + HL_W'(1);
              if (w_post == '0) w_state_nxt = DONE;
              else              w_target_nxt = w_post >> 1;
            end else begin
              w_tick_nxt = r_tick + TW'(1);
            end
          end
          // The pause cycle itself still counts, so the frozen span equals the pause length.
          if (w_pause_p && w_state_nxt == RUN) w_state_nxt = PAUSE;
        end
      end

      PAUSE: begin
        if (w_start_p)      w_state_nxt = LOAD;
        else if (w_pause_p) w_state_nxt = RUN;
      end

      DONE: begin
        if (w_start_p) w_state_nxt = LOAD;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_cnt_up   = 1'b0;
  assign o_busy     = (r_state == LOAD) || (r_state == SETTLE) ||
                      (r_state == RUN)  || (r_state == PAUSE);
  assign o_done     = (r_state == DONE);
  assign o_hl_count = r_hl;

endmodule

// File: tb/tb_halflife_decay_seq.sv
// Bench for halflife_decay_seq with a behavioural up/down counter closing the loop.
module tb_halflife_decay_seq;
  import halflife_pkg::*;

  localparam int N   = 4;
  localparam int PRE = 2;
  localparam int HT  = 10;
  localparam int HLW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_btn;
  logic           pause_btn;
  logic [N-1:0]   init_val;
  logic [N-1:0]   cnt_val;
  logic           o_cnt_load;
  logic           o_cnt_up;
  logic           o_cnt_down;
  logic [N-1:0]   o_cnt_in;
  logic           o_busy;
  logic           o_done;
  logic [HLW-1:0] o_hl_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int n_loads  = 0;
  int load_cyc = 0;
  int load_dat = 0;
  int q_down[$];
  int q_hl[$];
  logic [HLW-1:0] prev_hl = '0;
  logic           prev_down = 1'b0;

  typedef struct {
    int init;
    int exp_hl;
    int exp_downs;
  } vec_t;

  halflife_decay_seq #(
    .N(N), .PRESCALE(PRE), .HALF_TICKS(HT), .HL_W(HLW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start_btn(start_btn),
    .i_pause_btn(pause_btn),
    .i_init_val (init_val),
    .i_cnt_val  (cnt_val),
    .o_cnt_load (o_cnt_load),
    .o_cnt_up   (o_cnt_up),
    .o_cnt_down (o_cnt_down),
    .o_cnt_in   (o_cnt_in),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_hl_count (o_hl_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream up/down counter
  always @(posedge clk) begin
    if (rst)             cnt_val <= '0;
    else if (o_cnt_load) cnt_val <= o_cnt_in;
    else if (o_cnt_up)   cnt_val <= cnt_val + 4'd1;
    else if (o_cnt_down) cnt_val <= cnt_val - 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle invariants and event capture
  always @(negedge clk) begin
    chk("cnt_up_zero", {31'd0, o_cnt_up}, 0);
    chk("one_strobe", ($countones({o_cnt_load, o_cnt_up, o_cnt_down}) <= 1), 1);
    chk("busy_done_excl", {31'd0, o_busy & o_done}, 0);
    chk("cnt_in_idle", o_cnt_load ? 32'd0 : {28'd0, o_cnt_in}, 0);
    chk("down_width", {31'd0, o_cnt_down & prev_down}, 0);
    if (o_cnt_load) begin
      n_loads++;
      load_cyc = cyc;
      load_dat = int'(o_cnt_in);
      q_down.delete();
      q_hl.delete();
    end
    if (o_cnt_down) q_down.push_back(cyc);
    if (o_hl_count != prev_hl && o_hl_count != '0) q_hl.push_back(int'(cnt_val));
    prev_hl   = o_hl_count;
    prev_down = o_cnt_down;
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_loads = 0;
    q_down.delete();
    q_hl.delete();
  endtask

  task automatic press(input logic s, input logic p, input int hold);
    start_btn = s;
    pause_btn = p;
    repeat (hold) nxt();
    start_btn = 1'b0;
    pause_btn = 1'b0;
  endtask

  task automatic wait_loads(input int n);
    for (int i = 0; i < 60 && n_loads < n; i++) nxt();
    chk("load_seen", (n_loads >= n), 1);
  endtask

  function automatic int model_periods(input int v);
    int p = 0;
    while (v > 0) begin
      v = v >> 1;
      p++;
    end
    return p;
  endfunction

  // Reference: each period starts at value v, issues v-(v>>1) downs on its first ticks,
  // ends at v>>1; ticks occur every PRE cycles starting PRE+1 cycles after LOAD.
  task automatic check_run(input int init, input int exp_hl, input int exp_downs,
                           input int shift_from, input int shift, input int exp_loads);
    int  exp_q[$];
    int  exp_chain[$];
    int  v, k0, nd, np, done_exp, done_cyc;
    bit  seen;
    seen = 0;
    done_cyc = -1;
    for (int i = 0; i < 600 && !seen; i++) begin
      nxt();
      if (o_done === 1'b1 && n_loads >= exp_loads) begin
        seen = 1;
        done_cyc = cyc;
      end
    end
    chk("done_reached", {31'd0, seen}, 1);
    if (!seen) return;
    v = init; k0 = 0; np = 0;
    while (v > 0) begin
      nd = v - (v >> 1);
      for (int j = 0; j < nd; j++) exp_q.push_back(load_cyc + 1 + PRE * (k0 + j + 1));
      exp_chain.push_back(v >> 1);
      k0 += HT;
      v = v >> 1;
      np++;
    end
    done_exp = load_cyc + 2 + PRE * HT * np + shift;
    foreach (exp_q[i]) if (shift > 0 && exp_q[i] > shift_from) exp_q[i] += shift;

    chk("load_count", n_loads, exp_loads);
    chk("load_data", load_dat, init);
    chk("hl_count", {28'd0, o_hl_count}, exp_hl);
    chk("done_cycle", done_cyc, done_exp);
    chk("down_total", q_down.size(), exp_downs);
    for (int i = 0; i < exp_q.size(); i++)
      chk("down_cycle", (i < q_down.size()) ? q_down[i] : -1, exp_q[i]);
    chk("period_count", q_hl.size(), exp_chain.size());
    for (int i = 0; i < exp_chain.size(); i++)
      chk("period_end_val", (i < q_hl.size()) ? q_hl[i] : -1, exp_chain[i]);
    chk("final_val", {28'd0, cnt_val}, 0);
    repeat (3) nxt();
    chk("done_held", {31'd0, o_done}, 1);
    chk("busy_off", {31'd0, o_busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   v, r, lc;
    tbl[0] = '{12, 4, 12};
    tbl[1] = '{0,  0, 0};
    tbl[2] = '{15, 4, 15};
    tbl[3] = '{1,  1, 1};
    tbl[4] = '{8,  4, 8};
    tbl[5] = '{5,  3, 5};

    rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; init_val = '0;
    repeat (3) nxt();
    chk("reset_outs", {o_cnt_load, o_cnt_up, o_cnt_down, o_cnt_in, o_busy, o_done, o_hl_count}, 0);
    chk("reset_state", {31'd0, dut.r_state == IDLE}, 1);
    rst = 1'b0;
    repeat (2) nxt();

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      init_val = N'(tbl[i].init);
      press(1'b1, 1'b0, 2);
      check_run(tbl[i].init, tbl[i].exp_hl, tbl[i].exp_downs, 0, 0, 1);
    end

    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 15));
      clear_mon();
      init_val = N'(v);
      press(1'b1, 1'b0, 2);
      check_run(v, model_periods(v), v, 0, 0, 1);
    end

    // Pause on tick 3 held 50 cycles, resume 5 cycles after release
    clear_mon();
    init_val = 4'd15;
    press(1'b1, 1'b0, 2);
    wait_loads(1);
    repeat (6) nxt();
    pause_btn = 1'b1;
    r = cyc;
    repeat (50) nxt();
    pause_btn = 1'b0;
    chk("paused_busy", {31'd0, o_busy}, 1);
    chk("paused_downs", q_down.size(), 4);
    repeat (5) nxt();
    pause_btn = 1'b1;
    repeat (2) nxt();
    pause_btn = 1'b0;
    check_run(15, 4, 15, r + 3, 55, 1);

    // Start held 40 cycles gives a single load
    clear_mon();
    init_val = 4'd12;
    press(1'b1, 1'b0, 40);
    check_run(12, 4, 12, 0, 0, 1);

    // Restart mid-run with a new value
    clear_mon();
    init_val = 4'd12;
    press(1'b1, 1'b0, 2);
    wait_loads(1);
    lc = load_cyc;
    repeat (30) nxt();
    chk("hl_before_restart", {28'd0, o_hl_count}, 1);
    init_val = 4'd9;
    press(1'b1, 1'b0, 2);
    wait_loads(2);
    chk("restart_load_moved", (load_cyc > lc), 1);
    nxt();
    chk("hl_cleared", {28'd0, o_hl_count}, 0);
    check_run(9, 4, 9, 0, 0, 2);

    // Start and pause in the same cycle: start wins
    clear_mon();
    init_val = 4'd12;
    press(1'b1, 1'b0, 2);
    wait_loads(1);
    repeat (15) nxt();
    init_val = 4'd5;
    press(1'b1, 1'b1, 2);
    check_run(5, 3, 5, 0, 0, 2);

    // Reset mid-run
    clear_mon();
    init_val = 4'd12;
    press(1'b1, 1'b0, 2);
    wait_loads(1);
    repeat (25) nxt();
    chk("pre_rst_busy", {31'd0, o_busy}, 1);
    rst = 1'b1;
    nxt();
    chk("rst_outs", {o_cnt_load, o_cnt_up, o_cnt_down, o_cnt_in, o_busy, o_done, o_hl_count}, 0);
    chk("rst_state", {31'd0, dut.r_state == IDLE}, 1);
    repeat (2) begin
      nxt();
      chk("rst_quiet", {30'd0, o_cnt_load, o_cnt_down}, 0);
    end
    rst = 1'b0;
    repeat (10) nxt();
    chk("post_rst_idle", {31'd0, dut.r_state == IDLE}, 1);
    chk("post_rst_loads", n_loads, 1);
    chk("post_rst_flags", {30'd0, o_busy, o_done}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
